// File: rtl/div_iter.sv
// Multi-cycle signed restoring divider: one quotient bit per clock, trial
// subtraction through a 4-bit-group carry-lookahead adder.
module div_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_div,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_resultRDY
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned NGRP  = WIDTH / 4;

    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             sign_q, sign_q_n, sign_r, sign_r_n, dz, dz_n;
    logic [WIDTH-1:0] abs_b, abs_b_n, quo, quo_n;
    logic [WIDTH:0]   rem, rem_n;
    logic [WIDTH-1:0] result_n, remainder_n;
    logic             exc_n, rdy_n;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] quo_sh;
    logic [WIDTH-1:0] add_a, add_b, add_sum, gen, prop, bit_c;
    logic [NGRP:0]    grp_c;
    logic             add_cout, nonneg;

    // Trial subtraction rem_sh - |B| formed as rem_sh + ~|B| + 1
    always_comb begin
        rem_sh = {rem[WIDTH-1:0], quo[WIDTH-1]};
        quo_sh = {quo[WIDTH-2:0], 1'b0};
        add_a  = rem_sh[WIDTH-1:0];
        add_b  = ~abs_b;
        gen    = add_a & add_b;
        prop   = add_a ^ add_b;
        grp_c  = '0;
        bit_c  = '0;
        grp_c[0] = 1'b1;
        for (int j = 0; j < int'(NGRP); j++) begin
            grp_c[j+1] = gen[4*j+3]
                       | (prop[4*j+3] & gen[4*j+2])
                       | (prop[4*j+3] & prop[4*j+2] & gen[4*j+1])
                       | (prop[4*j+3] & prop[4*j+2] & prop[4*j+1] & gen[4*j])
                       | ((&prop[4*j +: 4]) & grp_c[j]);
            bit_c[4*j] = grp_c[j];
            for (int k = 1; k < 4; k++) begin
                bit_c[4*j+k] = gen[4*j+k-1] | (prop[4*j+k-1] & bit_c[4*j+k-1]);
            end
        end
        add_sum  = prop ^ bit_c;
        add_cout = grp_c[NGRP];
        // Any set bit above the adder width means the trial cannot go negative
        nonneg   = rem[WIDTH] | rem_sh[WIDTH] | add_cout;
    end

    // Next-state and datapath update
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        sign_q_n    = sign_q;
        sign_r_n    = sign_r;
        dz_n        = dz;
        abs_b_n     = abs_b;
        quo_n       = quo;
        rem_n       = rem;
        result_n    = data_result;
        remainder_n = data_remainder;
        exc_n       = 1'b0;
        rdy_n       = 1'b0;

        if (ctrl_div) begin
            sign_q_n = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            sign_r_n = data_operandA[WIDTH-1];
            quo_n    = data_operandA[WIDTH-1] ? WIDTH'(-data_operandA) : data_operandA;
            abs_b_n  = data_operandB[WIDTH-1] ? WIDTH'(-data_operandB) : data_operandB;
            rem_n    = '0;
            cnt_n    = '0;
            dz_n     = (data_operandB == '0);
            state_n  = (data_operandB == '0) ? DONE : ITER;
        end else begin
            case (state)
                ITER: begin
                    rem_n = nonneg ? {1'b0, add_sum} : rem_sh;
                    quo_n = {quo_sh[WIDTH-1:1], nonneg};
                    cnt_n = CNT_W'(cnt + 1'b1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state_n = FIX;
                    end
                end
                FIX: begin
                    result_n    = sign_q ? WIDTH'(-quo) : quo;
                    remainder_n = sign_r ? WIDTH'(-rem[WIDTH-1:0]) : rem[WIDTH-1:0];
                    rdy_n       = 1'b1;
                    state_n     = DONE;
                end
                DONE: begin
                    if (dz) begin
                        result_n    = '0;
                        remainder_n = '0;
                        exc_n       = 1'b1;
                        rdy_n       = 1'b1;
                        dz_n        = 1'b0;
                    end else begin
                        state_n = IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            sign_q         <= 1'b0;
            sign_r         <= 1'b0;
            dz             <= 1'b0;
            abs_b          <= '0;
            quo            <= '0;
            rem            <= '0;
            data_result    <= '0;
            data_remainder <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            sign_q         <= sign_q_n;
            sign_r         <= sign_r_n;
            dz             <= dz_n;
            abs_b          <= abs_b_n;
            quo            <= quo_n;
            rem            <= rem_n;
            data_result    <= result_n;
            data_remainder <= remainder_n;
            data_exception <= exc_n;
            data_resultRDY <= rdy_n;
        end
    end

endmodule

// File: doc/div_iter.md
Name: div_iter

Overview:
- Multi-cycle 32-bit signed integer divider for the ALU/multdiv path.
- Performs the inverse of the adder datapath: restoring division, one quotient bit per cycle.
- Each trial subtraction is formed as A + ~B + 1 through the team's 32-bit carry-lookahead adder.
- Sits beside the multiplier. The pipeline stalls on ctrl_div until data_resultRDY pulses.

Parameters:
- WIDTH, 32, operand/result width; the iteration count equals WIDTH.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- ctrl_div  input  1  start pulse; operands are sampled on the edge where it is 1
- data_operandA  input  32  dividend, two's complement
- data_operandB  input  32  divisor, two's complement
- data_result  output  32  quotient, truncated toward zero
- data_remainder  output  32  remainder; its sign follows the dividend
- data_exception  output  1  divide-by-zero flag, valid while data_resultRDY=1
- data_resultRDY  output  1  one-cycle completion pulse

Behaviour:
- Reset: clock and reset as above, reset synchronous and active-high.
  - Reset forces state IDLE.
  - data_result, data_remainder, data_exception and data_resultRDY all become 0.
  - Reset takes priority over ctrl_div on the same edge.
- States: IDLE, ITER, FIX, DONE.
- Edge E0 (ctrl_div=1, any state except reset):
  - Latch sign_q = A[31]^B[31] and sign_r = A[31].
  - Latch |A| and |B| as unsigned 32-bit values; |0x80000000| = 0x80000000.
  - Clear the 33-bit partial remainder and the counter.
  - If B==0, go to DONE with exception pending. Otherwise go to ITER.
- ITER, edges E1..E32 (counter 0..31):
  - Shift {rem, quo} left by 1.
  - Compute the trial value rem - |B| via the adder.
  - If the trial is non-negative (adder carry-out=1), rem <= trial and quo[0] <= 1. Otherwise quo[0] <= 0.
  - Leave ITER after count 31.
- FIX, edge E33:
  - data_result <= sign_q ? -quo : quo.
  - data_remainder <= sign_r ? -rem : rem.
  - data_exception <= 0, data_resultRDY <= 1, go to DONE.
- Divide by zero, edge E1:
  - data_result=0, data_remainder=0, data_exception=1, data_resultRDY=1.
- DONE: the next edge clears data_resultRDY and data_exception and goes to IDLE.
- Latency: data_resultRDY is high for exactly one cycle.
  - Normal divide: high after E33.
  - Divide by zero: high after E1.
- Output hold: data_result and data_remainder hold their values until the next FIX or divide-by-zero completion, or reset. They do not change during ITER.
- Overflow: 0x80000000 / -1 yields 0x80000000 (wrap), remainder 0, data_exception=0.
- Restart: ctrl_div=1 while in ITER/FIX/DONE aborts the current operation and restarts at E0 with the new operands.
  - The aborted operation never asserts data_resultRDY.
  - Outputs keep their prior values until the new completion.
  - If ctrl_div=1 coincides with the DONE edge, data_resultRDY still drops that edge and the new operation begins.
- Operand changes after E0 are ignored.
- ctrl_div held high for several cycles restarts on every edge. Completion requires ctrl_div to be low during E1..E33.

Test Plan:
- Reset, then ctrl_div with A=100, B=7 → data_resultRDY=1 only after E33; result=14, remainder=2, exception=0; RDY is 0 on every other edge.
- A=-100, B=7 → result=0xFFFFFFF2 (-14), remainder=0xFFFFFFFE (-2). A=100, B=-7 → result=-14, remainder=2.
- A=12345, B=0 → after E1: RDY=1, exception=1, result=0; after E2: RDY=0, exception=0.
- A=0x80000000, B=0xFFFFFFFF → result=0x80000000, remainder=0, exception=0. A=0x7FFFFFFF, B=1 → result=0x7FFFFFFF.
- Start A=100, B=7. At E10 start A=50, B=5 → no RDY at the original E33; RDY exactly at E10+33 with result=10, remainder=0.
- Start A=100, B=7, assert reset at E20 → outputs 0, state IDLE, no RDY afterward. A subsequent 9/3 returns 3 with RDY after its E33.
